ex_alu_branch_unit: RTL and testbench
=====================================

Name: ex_alu_branch_unit

Overview:
Execute-stage datapath block of the 5-stage RV32I pipeline. It contains three parts:
- the 32-bit ALU with Z/N/C/V flags;
- the condition handler, which turns the flags and a 3-bit branch type into a taken/not-taken decision;
- the 32-bit target-address adder (pc + imm).
Combinational results feed the IF-stage PC mux and forwarding paths. A registered copy feeds the EX/MEM boundary.

Parameters:
- WIDTH, 32, datapath width of operands, result, pc, imm and target address.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- load_enable  in  1  1 = update output registers; 0 = hold (stall).
- alu_op  in  4  ALU operation select.
- op_a  in  WIDTH  ALU operand A (rs1 value or PC, selected upstream).
- op_b  in  WIDTH  ALU operand B (second operand handler output).
- br_type  in  3  branch condition select.
- branch_en  in  1  current instruction is a conditional branch.
- pc  in  WIDTH  instruction PC.
- imm  in  WIDTH  sign-extended branch/jump offset.
- alu_out  out  WIDTH  combinational ALU result.
- z, n, c, v  out  1 each  combinational flags.
- cond_true  out  1  combinational condition-handler result.
- target_addr  out  WIDTH  combinational pc + imm.
- r_alu_out  out  WIDTH  registered alu_out.
- r_flags  out  4  registered {z,n,c,v}.
- r_taken  out  1  registered (cond_true & branch_en).
- r_target  out  WIDTH  registered target_addr.

Behaviour:
- ALU encodings (fully combinational); any other code gives 0:
  - 0000 ADD A+B
  - 0001 SUB A-B
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLL A<<B[4:0]
  - 0110 SRL
  - 0111 SRA (arithmetic)
  - 1000 SLT (signed, result 0/1)
  - 1001 SLTU (result 0/1)
  - 1010 PASS_B (LUI)
  - 1011 PASS_A
- Z: 1 iff alu_out==0. N: alu_out[WIDTH-1].
- C:
  - ADD: carry-out of bit WIDTH-1.
  - SUB: carry-out of A + ~B + 1, so C=1 iff A>=B unsigned.
  - All other ops: 0.
- V:
  - ADD: A,B same sign and result sign differs.
  - SUB: A,B signs differ and result sign differs from A.
  - All other ops: 0.
- Overflow wraps modulo 2^WIDTH; no saturation.
- Branches are evaluated with alu_op=SUB, so flags always reflect A-B.
- Condition handler (combinational, from br_type):
  - 000 EQ: Z
  - 001 NE: !Z
  - 100 LT: N^V
  - 101 GE: !(N^V)
  - 110 LTU: !C
  - 111 GEU: C
  - 010, 011: 0
- cond_true is independent of branch_en; the gating happens only in r_taken.
- target_addr = pc + imm, modulo 2^WIDTH, combinational, no carry output.
- Registers:
  - While reset=0 (async): r_alu_out=0, r_flags=0, r_taken=0, r_target=0.
  - On the first rising clk edge after reset rises, with load_enable=1: the registers capture the current combinational values.
  - load_enable=0: all registers hold.
  - Asserting reset mid-operation clears the registers immediately, without waiting for clk.
- Latency: combinational outputs 0 cycles; registered outputs 1 cycle.

Decomposition:
- Shared package ex_pkg:
  - ALU op localparams: ALU_ADD … ALU_PASS_A.
  - Branch type localparams: BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU.
  - WIDTH default.
- Sub-module ex_alu_core: ALU plus flag generation, purely combinational.
- Condition decode, target adder and registers stay in the top level.

Test Plan:
- ADD 0x7FFFFFFF+1 -> alu_out=0x80000000, N=1, V=1, C=0, Z=0. ADD 0xFFFFFFFF+1 -> alu_out=0, Z=1, C=1, V=0.
- SUB 5-5 with br_type=000, branch_en=1 -> Z=1, cond_true=1; after one clk edge r_taken=1. Same with branch_en=0 -> r_taken=0.
- SUB A=-3 (0xFFFFFFFD), B=2:
  - br_type=100 (LT) -> cond_true=1.
  - br_type=110 (LTU) -> cond_true=0 (C=1).
  - br_type=111 (GEU) -> cond_true=1.
- Shifts/compares with A=0x80000000, B=4:
  - SRA -> 0xF8000000; SRL -> 0x08000000; SLL(A=1,B=33) -> 2.
  - SLT -> 1; SLTU -> 0.
- pc=0x00000010, imm=0xFFFFFFF8 -> target_addr=0x00000008. pc=0xFFFFFFFC, imm=8 -> 0x00000004 (wrap).
- Drive reset=0 between clock edges while registers hold nonzero values -> all r_* outputs become 0 immediately. With load_enable=0 and changing inputs, r_* are unchanged across 3 edges.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings and defaults for the RV32I execute stage.
// ALU op codes, branch condition codes and the default datapath width.
package ex_pkg;

    localparam int EX_WIDTH = 32;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_SLL    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_SLT    = 4'b1000;
    localparam logic [3:0] ALU_SLTU   = 4'b1001;
    localparam logic [3:0] ALU_PASS_B = 4'b1010;
    localparam logic [3:0] ALU_PASS_A = 4'b1011;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

endpackage

// File: rtl/ex_alu_core.sv
// Combinational ALU with Z/N/C/V flag generation.
// C and V are only meaningful for ADD and SUB; all other ops clear them.
module ex_alu_core
    import ex_pkg::*;
#(
    parameter int WIDTH = EX_WIDTH
) (
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] alu_out,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [SHW-1:0]   w_shamt;
    logic             w_slt;
    logic             w_sltu;
    logic             w_sa;
    logic             w_sb;

    assign w_sa    = op_a[WIDTH-1];
    assign w_sb    = op_b[WIDTH-1];
    assign w_shamt = op_b[SHW-1:0];

    // SUB as A + ~B + 1 so the carry-out means A >= B unsigned
    assign w_add  = {1'b0, op_a} + {1'b0, op_b};
    assign w_sub  = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_slt  = $signed(op_a) < $signed(op_b);
    assign w_sltu = op_a < op_b;

    always_comb begin
        alu_out = '0;
        c       = 1'b0;
        v       = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                alu_out = w_add[WIDTH-1:0];
                c       = w_add[WIDTH];
                v       = (w_sa == w_sb) && (w_add[WIDTH-1] != w_sa);
            end
            ALU_SUB: begin
                alu_out = w_sub[WIDTH-1:0];
                c       = w_sub[WIDTH];
                v       = (w_sa != w_sb) && (w_sub[WIDTH-1] != w_sa);
            end
            ALU_AND:    alu_out = op_a & op_b;
            ALU_OR:     alu_out = op_a | op_b;
            ALU_XOR:    alu_out = op_a ^ op_b;
            ALU_SLL:    alu_out = op_a << w_shamt;
            ALU_SRL:    alu_out = op_a >> w_shamt;
            ALU_SRA:    alu_out = WIDTH'($signed(op_a) >>> w_shamt);
            ALU_SLT:    alu_out = {{(WIDTH-1){1'b0}}, w_slt};
            ALU_SLTU:   alu_out = {{(WIDTH-1){1'b0}}, w_sltu};
            ALU_PASS_B: alu_out = op_b;
            ALU_PASS_A: alu_out = op_a;
            default:    alu_out = '0;
        endcase
    end

    assign z = (alu_out == '0);
    assign n = alu_out[WIDTH-1];

endmodule

// File: rtl/ex_alu_branch_unit.sv
// Execute-stage ALU, branch condition handler and target adder.
// Combinational results feed IF/forwarding; a registered copy feeds EX/MEM.
module ex_alu_branch_unit
    import ex_pkg::*;
#(
    parameter int WIDTH = EX_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_enable,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       br_type,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] alu_out,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v,
    output logic             cond_true,
    output logic [WIDTH-1:0] target_addr,
    output logic [WIDTH-1:0] r_alu_out,
    output logic [3:0]       r_flags,
    output logic             r_taken,
    output logic [WIDTH-1:0] r_target
);

    ex_alu_core #(
        .WIDTH (WIDTH)
    ) u_alu (
        .alu_op  (alu_op),
        .op_a    (op_a),
        .op_b    (op_b),
        .alu_out (alu_out),
        .z       (z),
        .n       (n),
        .c       (c),
        .v       (v)
    );

    // Flags are expected to come from SUB when a branch is evaluated
    always_comb begin
        cond_true = 1'b0;
        case (br_type)
            BR_EQ:   cond_true = z;
            BR_NE:   cond_true = !z;
            BR_LT:   cond_true = n ^ v;
            BR_GE:   cond_true = !(n ^ v);
            BR_LTU:  cond_true = !c;
            BR_GEU:  cond_true = c;
            default: cond_true = 1'b0;
        endcase
    end

    assign target_addr = pc + imm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_out <= '0;
            r_flags   <= '0;
            r_taken   <= 1'b0;
            r_target  <= '0;
        end else if (load_enable) begin
            r_alu_out <= alu_out;
            r_flags   <= {z, n, c, v};
            r_taken   <= cond_true & branch_en;
            r_target  <= target_addr;
        end
    end

endmodule

// File: tb/tb_ex_alu_branch_unit.sv
// Self-checking bench for ex_alu_branch_unit: vector table for the
// combinational paths, scoreboard queue for the registered outputs.
module tb_ex_alu_branch_unit;

    logic        clk;
    logic        reset;
    logic        load_enable;
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  br_type;
    logic        branch_en;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] alu_out;
    logic        z, n, c, v;
    logic        cond_true;
    logic [31:0] target_addr;
    logic [31:0] r_alu_out;
    logic [3:0]  r_flags;
    logic        r_taken;
    logic [31:0] r_target;

    ex_alu_branch_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_enable (load_enable),
        .alu_op      (alu_op),
        .op_a        (op_a),
        .op_b        (op_b),
        .br_type     (br_type),
        .branch_en   (branch_en),
        .pc          (pc),
        .imm         (imm),
        .alu_out     (alu_out),
        .z           (z),
        .n           (n),
        .c           (c),
        .v           (v),
        .cond_true   (cond_true),
        .target_addr (target_addr),
        .r_alu_out   (r_alu_out),
        .r_flags     (r_flags),
        .r_taken     (r_taken),
        .r_target    (r_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  bt;
        logic        ben;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] e_out;
        logic [3:0]  e_flags;
        logic        e_cond;
        logic [31:0] e_tgt;
    } vec_t;

    typedef struct {
        logic [31:0] alu;
        logic [3:0]  flags;
        logic        taken;
        logic [31:0] tgt;
    } reg_t;

    vec_t vecs[$];
    reg_t sb[$];
    reg_t last;
    reg_t got;
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] bt,
                           input logic ben, input logic [31:0] p,
                           input logic [31:0] im, input logic [31:0] eo,
                           input logic [3:0] ef, input logic ec,
                           input logic [31:0] et);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.bt = bt; t.ben = ben;
        t.pc = p; t.imm = im; t.e_out = eo; t.e_flags = ef;
        t.e_cond = ec; t.e_tgt = et;
        vecs.push_back(t);
    endtask

    task automatic check_regs(input string tag);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sb.pop_front();
            chk({tag, ".r_alu_out"}, r_alu_out, got.alu);
            chk({tag, ".r_flags"}, {28'd0, r_flags}, {28'd0, got.flags});
            chk({tag, ".r_taken"}, {31'd0, r_taken}, {31'd0, got.taken});
            chk({tag, ".r_target"}, r_target, got.tgt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // flags column is {z,n,c,v}
        add_vec(4'b0000, 32'h7FFFFFFF, 32'h1, 3'b000, 1'b0, 32'h0, 32'h0,
                32'h80000000, 4'b0101, 1'b0, 32'h0);
        add_vec(4'b0000, 32'hFFFFFFFF, 32'h1, 3'b000, 1'b0, 32'h10, 32'hFFFFFFF8,
                32'h0, 4'b1010, 1'b1, 32'h8);
        add_vec(4'b0001, 32'h5, 32'h5, 3'b000, 1'b1, 32'hFFFFFFFC, 32'h8,
                32'h0, 4'b1010, 1'b1, 32'h4);
        add_vec(4'b0001, 32'h5, 32'h5, 3'b000, 1'b0, 32'h100, 32'h20,
                32'h0, 4'b1010, 1'b1, 32'h120);
        add_vec(4'b0001, 32'hFFFFFFFD, 32'h2, 3'b100, 1'b1, 32'h0, 32'h4,
                32'hFFFFFFFB, 4'b0110, 1'b1, 32'h4);
        add_vec(4'b0001, 32'hFFFFFFFD, 32'h2, 3'b110, 1'b1, 32'h0, 32'h4,
                32'hFFFFFFFB, 4'b0110, 1'b0, 32'h4);
        add_vec(4'b0001, 32'hFFFFFFFD, 32'h2, 3'b111, 1'b1, 32'h0, 32'h4,
                32'hFFFFFFFB, 4'b0110, 1'b1, 32'h4);
        add_vec(4'b0001, 32'hFFFFFFFD, 32'h2, 3'b101, 1'b1, 32'h0, 32'h4,
                32'hFFFFFFFB, 4'b0110, 1'b0, 32'h4);
        add_vec(4'b0001, 32'hFFFFFFFD, 32'h2, 3'b001, 1'b1, 32'h0, 32'h4,
                32'hFFFFFFFB, 4'b0110, 1'b1, 32'h4);
        add_vec(4'b0001, 32'hFFFFFFFD, 32'h2, 3'b010, 1'b1, 32'h0, 32'h4,
                32'hFFFFFFFB, 4'b0110, 1'b0, 32'h4);
        add_vec(4'b0111, 32'h80000000, 32'h4, 3'b000, 1'b0, 32'h0, 32'h0,
                32'hF8000000, 4'b0100, 1'b0, 32'h0);
        add_vec(4'b0110, 32'h80000000, 32'h4, 3'b000, 1'b0, 32'h0, 32'h0,
                32'h08000000, 4'b0000, 1'b0, 32'h0);
        add_vec(4'b0101, 32'h1, 32'd33, 3'b000, 1'b0, 32'h0, 32'h0,
                32'h2, 4'b0000, 1'b0, 32'h0);
        add_vec(4'b1000, 32'h80000000, 32'h4, 3'b000, 1'b0, 32'h0, 32'h0,
                32'h1, 4'b0000, 1'b0, 32'h0);
        add_vec(4'b1001, 32'h80000000, 32'h4, 3'b000, 1'b1, 32'h0, 32'h0,
                32'h0, 4'b1000, 1'b1, 32'h0);
        add_vec(4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 1'b0, 32'h0, 32'h0,
                32'hF000F000, 4'b0100, 1'b0, 32'h0);
        add_vec(4'b0011, 32'h0F0F0000, 32'h000000FF, 3'b000, 1'b0, 32'h0, 32'h0,
                32'h0F0F00FF, 4'b0000, 1'b0, 32'h0);
        add_vec(4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, 1'b0, 32'h0, 32'h0,
                32'h0, 4'b1000, 1'b1, 32'h0);
        add_vec(4'b1010, 32'h1, 32'hABCD0000, 3'b000, 1'b0, 32'h0, 32'h0,
                32'hABCD0000, 4'b0100, 1'b0, 32'h0);
        add_vec(4'b1011, 32'h12345678, 32'h1, 3'b000, 1'b0, 32'h0, 32'h0,
                32'h12345678, 4'b0000, 1'b0, 32'h0);
        add_vec(4'b1100, 32'h12345678, 32'h1, 3'b000, 1'b0, 32'h0, 32'h0,
                32'h0, 4'b1000, 1'b1, 32'h0);
        add_vec(4'b0001, 32'h80000000, 32'h1, 3'b100, 1'b1, 32'h1000, 32'h4,
                32'h7FFFFFFF, 4'b0011, 1'b1, 32'h1004);

        reset = 1'b0;
        load_enable = 1'b1;
        alu_op = 4'b0000;
        op_a = 32'h1;
        op_b = 32'h2;
        br_type = 3'b001;
        branch_en = 1'b1;
        pc = 32'h40;
        imm = 32'h4;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.r_alu_out", r_alu_out, 32'h0);
        chk("reset.r_flags", {28'd0, r_flags}, 32'h0);
        chk("reset.r_taken", {31'd0, r_taken}, 32'h0);
        chk("reset.r_target", r_target, 32'h0);

        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            alu_op    = vecs[i].op;
            op_a      = vecs[i].a;
            op_b      = vecs[i].b;
            br_type   = vecs[i].bt;
            branch_en = vecs[i].ben;
            pc        = vecs[i].pc;
            imm       = vecs[i].imm;
            #1;
            chk($sformatf("v%0d.alu_out", i), alu_out, vecs[i].e_out);
            chk($sformatf("v%0d.flags", i), {28'd0, z, n, c, v},
                {28'd0, vecs[i].e_flags});
            chk($sformatf("v%0d.cond_true", i), {31'd0, cond_true},
                {31'd0, vecs[i].e_cond});
            chk($sformatf("v%0d.target", i), target_addr, vecs[i].e_tgt);
            last.alu   = vecs[i].e_out;
            last.flags = vecs[i].e_flags;
            last.taken = vecs[i].e_cond & vecs[i].ben;
            last.tgt   = vecs[i].e_tgt;
            sb.push_back(last);
            @(posedge clk);
            #1;
            check_regs($sformatf("v%0d", i));
        end

        // stall: inputs change but registers must hold the last capture
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            load_enable = 1'b0;
            alu_op    = 4'b0000;
            op_a      = 32'h1111 * (k + 1);
            op_b      = 32'h22;
            br_type   = 3'b001;
            branch_en = 1'b1;
            pc        = 32'h800 + k;
            imm       = 32'h10;
            sb.push_back(last);
            @(posedge clk);
            #1;
            check_regs($sformatf("hold%0d", k));
        end

        // async clear between edges
        #2;
        reset = 1'b0;
        #1;
        chk("async.r_alu_out", r_alu_out, 32'h0);
        chk("async.r_flags", {28'd0, r_flags}, 32'h0);
        chk("async.r_taken", {31'd0, r_taken}, 32'h0);
        chk("async.r_target", r_target, 32'h0);

        // first capture after reset release
        @(negedge clk);
        reset = 1'b1;
        load_enable = 1'b1;
        alu_op = 4'b0001;
        op_a = 32'h9;
        op_b = 32'h9;
        br_type = 3'b000;
        branch_en = 1'b1;
        pc = 32'h200;
        imm = 32'hFFFFFF00;
        last.alu = 32'h0;
        last.flags = 4'b1010;
        last.taken = 1'b1;
        last.tgt = 32'h100;
        sb.push_back(last);
        @(posedge clk);
        #1;
        check_regs("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
